// File: rtl/ps2_kbd_pkg.sv
// Shared types for the PS/2 to ZX Spectrum matrix bridge: decoder states,
// prefix bytes and the set-2 scan code to matrix position lookup.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  localparam logic [7:0] PFX_E0    = 8'hE0;
  localparam logic [7:0] PFX_F0    = 8'hF0;
  localparam logic [7:0] PFX_AA    = 8'hAA;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t map_code(input logic [7:0] code);
    key_pos_t m;
    m.valid = 1'b1;
    case (code)
      8'h12, 8'h59: {m.row, m.col} = {3'd0, 3'd0};
      8'h1A: {m.row, m.col} = {3'd0, 3'd1};
      8'h22: {m.row, m.col} = {3'd0, 3'd2};
      8'h21: {m.row, m.col} = {3'd0, 3'd3};
      8'h2A: {m.row, m.col} = {3'd0, 3'd4};
      8'h1C: {m.row, m.col} = {3'd1, 3'd0};
      8'h1B: {m.row, m.col} = {3'd1, 3'd1};
      8'h23: {m.row, m.col} = {3'd1, 3'd2};
      8'h2B: {m.row, m.col} = {3'd1, 3'd3};
      8'h34: {m.row, m.col} = {3'd1, 3'd4};
      8'h15: {m.row, m.col} = {3'd2, 3'd0};
      8'h1D: {m.row, m.col} = {3'd2, 3'd1};
      8'h24: {m.row, m.col} = {3'd2, 3'd2};
      8'h2D: {m.row, m.col} = {3'd2, 3'd3};
      8'h2C: {m.row, m.col} = {3'd2, 3'd4};
      8'h16: {m.row, m.col} = {3'd3, 3'd0};
      8'h1E: {m.row, m.col} = {3'd3, 3'd1};
      8'h26: {m.row, m.col} = {3'd3, 3'd2};
      8'h25: {m.row, m.col} = {3'd3, 3'd3};
      8'h2E: {m.row, m.col} = {3'd3, 3'd4};
      8'h45: {m.row, m.col} = {3'd4, 3'd0};
      8'h46: {m.row, m.col} = {3'd4, 3'd1};
      8'h3E: {m.row, m.col} = {3'd4, 3'd2};
      8'h3D: {m.row, m.col} = {3'd4, 3'd3};
      8'h36: {m.row, m.col} = {3'd4, 3'd4};
      8'h4D: {m.row, m.col} = {3'd5, 3'd0};
      8'h44: {m.row, m.col} = {3'd5, 3'd1};
      8'h43: {m.row, m.col} = {3'd5, 3'd2};
      8'h3C: {m.row, m.col} = {3'd5, 3'd3};
      8'h35: {m.row, m.col} = {3'd5, 3'd4};
      8'h5A: {m.row, m.col} = {3'd6, 3'd0};
      8'h4B: {m.row, m.col} = {3'd6, 3'd1};
      8'h42: {m.row, m.col} = {3'd6, 3'd2};
      8'h3B: {m.row, m.col} = {3'd6, 3'd3};
      8'h33: {m.row, m.col} = {3'd6, 3'd4};
      8'h29: {m.row, m.col} = {3'd7, 3'd0};
      8'h14: {m.row, m.col} = {3'd7, 3'd1};
      8'h3A: {m.row, m.col} = {3'd7, 3'd2};
      8'h31: {m.row, m.col} = {3'd7, 3'd3};
      8'h32: {m.row, m.col} = {3'd7, 3'd4};
      default: begin
        m.valid = 1'b0;
        {m.row, m.col} = 6'd0;
      end
    endcase
    return m;
  endfunction

  function automatic logic [5:0] key_index(input logic [2:0] row, input logic [2:0] col);
    return ({3'b000, row} * 6'd5) + {3'b000, col};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-FF synchronisers, falling-edge sampling, 11-bit
// frame assembly with odd-parity/stop check and an idle watchdog.
module ps2_rx #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int WDOG_US = 2000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_rx_err
);

  localparam int WDOG_CYC = (CLK_HZ / 1_000_000) * WDOG_US;
  localparam int WW       = $clog2(WDOG_CYC);

  logic          r_clk_meta, r_clk_sync, r_clk_prev;
  logic          r_dat_meta, r_dat_sync;
  logic [3:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_valid, r_err;
  logic [WW-1:0] r_wdog;
  logic          w_fall, w_expire;

  assign w_fall   = r_clk_prev & ~r_clk_sync;
  assign w_expire = (r_wdog == WW'(WDOG_CYC - 1)) && (r_bitcnt != 4'd0) && !w_fall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_bitcnt   <= 4'd0;
      r_shift    <= 8'd0;
      r_par      <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= i_ps2_data;
      r_dat_sync <= r_dat_meta;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      if (w_fall)
        r_wdog <= '0;
      else if (r_wdog != WW'(WDOG_CYC - 1))
        r_wdog <= r_wdog + 1'b1;

      if (w_expire) begin
        r_bitcnt <= 4'd0;
        r_err    <= 1'b1;
      end else if (w_fall) begin
        case (r_bitcnt)
          4'd0: if (!r_dat_sync) r_bitcnt <= 4'd1;
          4'd9: begin
            r_par    <= r_dat_sync;
            r_bitcnt <= 4'd10;
          end
          4'd10: begin
            r_bitcnt <= 4'd0;
            // Odd parity: data plus parity bit must carry an odd number of ones.
            if (r_dat_sync && (^{r_shift, r_par}))
              r_valid <= 1'b1;
            else
              r_err <= 1'b1;
          end
          default: begin
            r_shift  <= {r_dat_sync, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        endcase
      end
    end
  end

  assign o_byte_valid = r_valid;
  assign o_byte       = r_shift;
  assign o_rx_err     = r_err;

endmodule

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 set-2 keyboard to 8x5 active-low ZX Spectrum key matrix.
// Optional PS2_CURSOR_KEYS_EN maps extended arrow keys to CS plus a digit.
module ps2_keyboard_matrix
  import ps2_kbd_pkg::*;
#(
  parameter int CLK_HZ  = 25_000_000,
  parameter int WDOG_US = 2000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [4:0] o_row_0,
  output logic [4:0] o_row_1,
  output logic [4:0] o_row_2,
  output logic [4:0] o_row_3,
  output logic [4:0] o_row_4,
  output logic [4:0] o_row_5,
  output logic [4:0] o_row_6,
  output logic [4:0] o_row_7,
  output logic       o_rx_err
);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  dec_state_t r_state, w_state_next;
  logic       w_act, w_val, w_ext, w_clear;
  key_pos_t   w_map;
  logic [5:0] w_idx;
  logic [39:0] r_keys;
  // CS sources: [0] left shift, [1] right shift, [5:2] arrows left/down/up/right
  logic [5:0]  r_cs_src;
  logic [39:0] w_pressed;
  logic [4:0]  w_rows [8];

  ps2_rx #(.CLK_HZ(CLK_HZ), .WDOG_US(WDOG_US)) u_rx (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ps2_clk    (i_ps2_clk),
    .i_ps2_data   (i_ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_rx_err     (o_rx_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_act   = 1'b0;
    w_val   = 1'b0;
    w_ext   = 1'b0;
    w_clear = 1'b0;
    if (w_byte_valid) begin
      case (r_state)
        IDLE: begin
          if (w_byte == PFX_E0)      w_state_next = EXT;
          else if (w_byte == PFX_F0) w_state_next = BRK;
          else if (w_byte == PFX_AA || w_byte == 8'h00 || w_byte == 8'hFF) w_clear = 1'b1;
          else begin
            w_act = 1'b1;
            w_val = 1'b1;
          end
        end
        EXT: begin
          if (w_byte == PFX_F0) w_state_next = EXT_BRK;
          else begin
            w_act = 1'b1;
            w_val = 1'b1;
            w_ext = 1'b1;
            w_state_next = IDLE;
          end
        end
        BRK: begin
          w_act = 1'b1;
          w_state_next = IDLE;
        end
        default: begin
          w_act = 1'b1;
          w_ext = 1'b1;
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign w_map = map_code(w_byte);
  assign w_idx = key_index(w_map.row, w_map.col);

  always_ff @(posedge i_clk) begin
    if (i_reset || w_clear) begin
      r_keys   <= '0;
      r_cs_src <= '0;
    end else if (w_act) begin
      if (!w_ext) begin
        if (w_byte == SC_LSHIFT)      r_cs_src[0] <= w_val;
        else if (w_byte == SC_RSHIFT) r_cs_src[1] <= w_val;
        else if (w_map.valid)         r_keys[w_idx] <= w_val;
      end
`ifdef PS2_CURSOR_KEYS_EN
      else begin
        case (w_byte)
          8'h6B: begin r_cs_src[2] <= w_val; r_keys[19] <= w_val; end
          8'h72: begin r_cs_src[3] <= w_val; r_keys[24] <= w_val; end
          8'h75: begin r_cs_src[4] <= w_val; r_keys[23] <= w_val; end
          8'h74: begin r_cs_src[5] <= w_val; r_keys[22] <= w_val; end
          default: ;
        endcase
      end
`endif
    end
  end

  assign w_pressed = {r_keys[39:1], r_keys[0] | (|r_cs_src)};

  for (genvar gi = 0; gi < 8; gi++) begin : g_rows
    assign w_rows[gi] = ~w_pressed[gi*5 +: 5];
  end

  assign o_row_0 = w_rows[0];
  assign o_row_1 = w_rows[1];
  assign o_row_2 = w_rows[2];
  assign o_row_3 = w_rows[3];
  assign o_row_4 = w_rows[4];
  assign o_row_5 = w_rows[5];
  assign o_row_6 = w_rows[6];
  assign o_row_7 = w_rows[7];

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed self-checking bench for ps2_keyboard_matrix; PS/2 frames are
// bit-banged with 20-cycle half periods and a shortened watchdog.
module tb_ps2_keyboard_matrix;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [4:0] row0, row1, row2, row3, row4, row5, row6, row7;
  logic rx_err;
  logic [39:0] all_rows;
  int n_tests = 0;
  int n_fail = 0;
  int err_cnt = 0;

  ps2_keyboard_matrix #(.CLK_HZ(25_000_000), .WDOG_US(200)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_row_0    (row0),
    .o_row_1    (row1),
    .o_row_2    (row2),
    .o_row_3    (row3),
    .o_row_4    (row4),
    .o_row_5    (row5),
    .o_row_6    (row6),
    .o_row_7    (row7),
    .o_rx_err   (rx_err)
  );

  always #5 clk = ~clk;

  assign all_rows = {row7, row6, row5, row4, row3, row2, row1, row0};

  always @(posedge clk) begin
    if (!reset && rx_err) err_cnt <= err_cnt + 1;
  end

  function automatic logic [4:0] rowv(input int r);
    return all_rows[r*5 +: 5];
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] check %-12s observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  logic [7:0] tbl_code [6] = '{8'h16, 8'h45, 8'h5A, 8'h14, 8'h4D, 8'h2A};
  int         tbl_row  [6] = '{3, 4, 6, 7, 5, 0};
  logic [4:0] tbl_exp  [6] = '{5'b11110, 5'b11110, 5'b11110, 5'b11101, 5'b11110, 5'b01111};
  logic [10:0] f;

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_rows", all_rows, {40{1'b1}});
    chk("reset_err", {39'd0, rx_err}, 40'd0);
    reset = 1'b0;
    repeat (10000) @(negedge clk);
    chk("idle_rows", all_rows, {40{1'b1}});
    chk("idle_err", 40'(err_cnt), 40'd0);

    // A (1C) with edge-to-row latency measured from the raw stop-bit fall
    f = mk_frame(8'h1C, 1'b0);
    send_bits(f, 10);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_early", 40'(rowv(1)), 40'(5'b11111));
    @(negedge clk);
    chk("a_make", 40'(rowv(1)), 40'(5'b11110));
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("a_break", 40'(rowv(1)), 40'(5'b11111));

    // parity error then a good left shift
    send_bits(mk_frame(8'h12, 1'b1), 11);
    repeat (10) @(negedge clk);
    chk("par_err", 40'(err_cnt), 40'd1);
    chk("par_row0", 40'(rowv(0)), 40'(5'b11111));
    send_byte(8'h12);
    chk("lsh_make", 40'(rowv(0)), 40'(5'b11110));
    send_byte(8'hF0);
    send_byte(8'h12);
    chk("lsh_break", 40'(rowv(0)), 40'(5'b11111));

    // truncated frame: watchdog abort
    send_bits(mk_frame(8'h29, 1'b0), 4);
    repeat (6000) @(negedge clk);
    chk("wdog_err", 40'(err_cnt), 40'd2);
    send_byte(8'h29);
    chk("space_make", 40'(rowv(7)), 40'(5'b11110));
    chk("wdog_once", 40'(err_cnt), 40'd2);
    send_byte(8'hF0);
    send_byte(8'h29);
    chk("space_brk", 40'(rowv(7)), 40'(5'b11111));

    // two shift sources share CS
    send_byte(8'h12);
    send_byte(8'h59);
    send_byte(8'hF0);
    send_byte(8'h12);
    chk("cs_hold", 40'(rowv(0)), 40'(5'b11110));
    send_byte(8'hF0);
    send_byte(8'h59);
    chk("cs_rel", 40'(rowv(0)), 40'(5'b11111));
    send_byte(8'h1A);
    send_byte(8'h22);
    chk("zx_make", 40'(rowv(0)), 40'(5'b11001));
    send_byte(8'hAA);
    chk("bat_clear", all_rows, {40{1'b1}});

    // assorted keys: press then release
    for (int i = 0; i < 6; i++) begin
      send_byte(tbl_code[i]);
      chk($sformatf("key_%h_mk", tbl_code[i]), 40'(rowv(tbl_row[i])), 40'(tbl_exp[i]));
      send_byte(8'hF0);
      send_byte(tbl_code[i]);
      chk($sformatf("key_%h_br", tbl_code[i]), all_rows, {40{1'b1}});
    end

    // extended cursor up
    send_byte(8'hE0);
    send_byte(8'h75);
`ifdef PS2_CURSOR_KEYS_EN
    chk("up_row0", 40'(rowv(0)), 40'(5'b11110));
    chk("up_row4", 40'(rowv(4)), 40'(5'b10111));
`else
    chk("up_ignored", all_rows, {40{1'b1}});
`endif
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("up_release", all_rows, {40{1'b1}});

    // reset mid-frame, then a stray suffix decodes as make
    send_byte(8'h1C);
    chk("pre_rst", 40'(rowv(1)), 40'(5'b11110));
    send_bits(mk_frame(8'hF0, 1'b0), 3);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clear", all_rows, {40{1'b1}});
    reset = 1'b0;
    send_byte(8'h1C);
    chk("stray_make", 40'(rowv(1)), 40'(5'b11110));
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("stray_fix", all_rows, {40{1'b1}});
    chk("final_err", 40'(err_cnt), 40'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
